// File: rtl/bus_arb_pkg.sv
// Shared FSM encoding and ramControl size/sign codes
// for the two-master data bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam int CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the master that
// was not granted most recently wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick,
    output logic       valid
);

    always_comb begin
        pick = 2'b00;
        unique case (1'b1)
            (req == 2'b01): pick = 2'b01;
            (req == 2'b10): pick = 2'b10;
            (req == 2'b11): pick = last ? 2'b01 : 2'b10;
            default:        pick = 2'b00;
        endcase
        valid = |req;
    end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master, one-slave round-robin arbiter: latch winner,
// one slave strobe, fixed read latency, one-cycle ready.
module bus_arbiter_2m
    import bus_arb_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [2:0]    m0_ctrl,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ready,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [2:0]    m1_ctrl,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ready,
    output logic          s_en,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic [2:0]    s_ctrl,
    input  logic [DW-1:0] s_rdata,
    output logic [1:0]    grant,
    output logic          busy
);

    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_lat
        $fatal(1, "bus_arbiter_2m: RD_LAT must be within 1..15");
    end

    localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LAT);

    state_t           state;
    state_t           state_d;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic [2:0]       ctrl_q;
    logic [1:0]       grant_q;
    logic [DW-1:0]    rdata0;
    logic [DW-1:0]    rdata1;
    logic [1:0]       pick;
    logic             pick_vld;

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last),
        .pick  (pick),
        .valid (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (pick_vld) state_d = ISSUE;
            ISSUE:   state_d = we_q ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command is captured once at the pick; the slave side
    // only ever sees these registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last    <= 1'b1;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ctrl_q  <= '0;
            grant_q <= 2'b00;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick;
                        we_q    <= pick[1] ? m1_we    : m0_we;
                        addr_q  <= pick[1] ? m1_addr  : m0_addr;
                        wdata_q <= pick[1] ? m1_wdata : m0_wdata;
                        ctrl_q  <= pick[1] ? m1_ctrl  : m0_ctrl;
                    end
                end
                ISSUE: begin
                    if (!we_q) cnt <= LAT;
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (grant_q[1]) rdata1 <= s_rdata;
                        else            rdata0 <= s_rdata;
                    end
                end
                RESP: begin
                    last    <= grant_q[1];
                    grant_q <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign s_en     = (state == ISSUE);
    assign s_we     = s_en & we_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_ctrl   = ctrl_q;
    assign grant    = grant_q;
    assign busy     = (state != IDLE);
    assign m0_ready = (state == RESP) & grant_q[0];
    assign m1_ready = (state == RESP) & grant_q[1];
    assign m0_rdata = rdata0;
    assign m1_rdata = rdata1;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Scoreboard bench for bus_arbiter_2m: transaction-level
// arbitration model feeds expected issue/response queues.
module tb_bus_arbiter_2m;
    import bus_arb_pkg::*;

    localparam int RD_LAT = 3;
    localparam int AW     = 32;
    localparam int DW     = 32;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
    } cmd_t;

    typedef struct {
        int   cyc;
        int   m;
        cmd_t c;
    } iss_t;

    typedef struct {
        int          cyc;
        int          m;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
    logic [2:0]    m0_ctrl, m1_ctrl, s_ctrl;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic          m0_ready, m1_ready, s_en, s_we, busy;
    logic [1:0]    grant;

    bus_arbiter_2m #(.RD_LAT(RD_LAT), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ctrl  (m0_ctrl),
        .m0_rdata (m0_rdata),
        .m0_ready (m0_ready),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ctrl  (m1_ctrl),
        .m1_rdata (m1_rdata),
        .m1_ready (m1_ready),
        .s_en     (s_en),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_ctrl   (s_ctrl),
        .s_rdata  (s_rdata),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dflt(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Slave: data is valid only in the single cycle the arbiter
    // is supposed to capture it; other cycles carry junk.
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] rd_data = '0;
    int          rd_k = 0;

    always @(posedge clk) begin
        if (s_en && s_we) slave_mem[s_addr] = s_wdata;
        if (s_en && !s_we) begin
            rd_k    <= 1;
            rd_data <= slave_mem.exists(s_addr) ? slave_mem[s_addr] : dflt(s_addr);
        end else if (rd_k != 0 && rd_k < 32) begin
            rd_k <= rd_k + 1;
        end
    end

    assign s_rdata = (rd_k == RD_LAT) ? rd_data : (~rd_data ^ 32'(rd_k));

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ref_rd [2];
    logic [2:0]  lsc [5];
    cmd_t        script0[$];
    cmd_t        script1[$];
    cmd_t        cmd [2];
    bit          pend [2];
    bit          act [2];
    bit          drop [2];
    int          done_at [2];
    int          last_w = 1;
    int          idle_at = 0;
    iss_t        iss_q[$];
    rsp_t        rsp_q[$];

    function automatic cmd_t mk(logic we, logic [31:0] a, logic [31:0] d, logic [2:0] c);
        cmd_t r;
        r.we = we; r.addr = a; r.wdata = d; r.ctrl = c;
        return r;
    endfunction

    function automatic cmd_t rand_cmd();
        return mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                  $urandom, lsc[$urandom_range(0, 4)]);
    endfunction

    task automatic drive(int m, logic r, cmd_t c);
        if (m == 0) begin
            m0_req = r; m0_we = c.we; m0_addr = c.addr;
            m0_wdata = c.wdata; m0_ctrl = c.ctrl;
        end else begin
            m1_req = r; m1_we = c.we; m1_addr = c.addr;
            m1_wdata = c.wdata; m1_ctrl = c.ctrl;
        end
    endtask

    task automatic step(bit rnd);
        int n = cyc;
        for (int m = 0; m < 2; m++) begin
            if (act[m] && n > done_at[m]) act[m] = 0;
            if (!pend[m] && !act[m]) begin
                if (m == 0 && script0.size() > 0) begin
                    cmd[0] = script0.pop_front(); pend[0] = 1;
                end else if (m == 1 && script1.size() > 0) begin
                    cmd[1] = script1.pop_front(); pend[1] = 1;
                end else if (rnd && $urandom_range(0, 2) == 0) begin
                    cmd[m] = rand_cmd(); pend[m] = 1;
                end
            end
            if (pend[m] || (act[m] && !drop[m])) drive(m, 1'b1, cmd[m]);
            else drive(m, 1'b0, rand_cmd());
        end
        if (n >= idle_at && (pend[0] || pend[1])) begin
            int   w;
            int   lat;
            iss_t it;
            rsp_t rs;
            w   = (pend[0] && pend[1]) ? 1 - last_w : (pend[0] ? 0 : 1);
            lat = cmd[w].we ? 0 : RD_LAT;
            if (cmd[w].we) ref_mem[cmd[w].addr] = cmd[w].wdata;
            else ref_rd[w] = ref_mem.exists(cmd[w].addr) ?
                             ref_mem[cmd[w].addr] : dflt(cmd[w].addr);
            it.cyc = n + 1; it.m = w; it.c = cmd[w];
            iss_q.push_back(it);
            rs.cyc = n + 2 + lat; rs.m = w;
            rs.rd0 = ref_rd[0]; rs.rd1 = ref_rd[1];
            rsp_q.push_back(rs);
            done_at[w] = n + 2 + lat;
            idle_at    = n + 3 + lat;
            pend[w] = 0;
            act[w]  = 1;
            drop[w] = rnd && ($urandom_range(0, 1) == 1);
            last_w  = w;
        end
    endtask

    task automatic run(int ncyc, bit rnd);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            step(rnd);
        end
    endtask

    task automatic settle();
        int k = 0;
        while (k < 400 && (pend[0] || pend[1] || act[0] || act[1] ||
               cyc < idle_at || script0.size() > 0 || script1.size() > 0)) begin
            @(posedge clk); #1;
            step(1'b0);
            k++;
        end
    endtask

    task automatic apply_reset(int ncyc);
        reset = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; act[m] = 0; drop[m] = 0;
        end
        iss_q.delete();
        rsp_q.delete();
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_ctl", 64'({s_en, s_we, s_ctrl, grant, busy, m0_ready, m1_ready}), 64'h0);
            chk("rst_s_addr", 64'(s_addr), 64'h0);
            chk("rst_s_wdata", 64'(s_wdata), 64'h0);
            chk("rst_m0_rdata", 64'(m0_rdata), 64'h0);
            chk("rst_m1_rdata", 64'(m1_rdata), 64'h0);
        end
        @(posedge clk); #1;
        reset   = 1'b1;
        last_w  = 1;
        idle_at = cyc;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
    endtask

    // Monitor: compares whatever the DUT presents against the queue heads.
    always @(negedge clk) begin
        iss_t it;
        rsp_t rs;
        bit   due, d0, d1;
        if (iss_q.size() > 0 && iss_q[0].cyc < cyc) it = iss_q.pop_front();
        due = iss_q.size() > 0 && iss_q[0].cyc == cyc;
        chk("s_en", 64'(s_en), 64'(due));
        if (s_en && iss_q.size() > 0) begin
            it = iss_q.pop_front();
            chk("iss_cycle", 64'(cyc), 64'(it.cyc));
            chk("s_we", 64'(s_we), 64'(it.c.we));
            chk("s_addr", 64'(s_addr), 64'(it.c.addr));
            chk("s_wdata", 64'(s_wdata), 64'(it.c.wdata));
            chk("s_ctrl", 64'(s_ctrl), 64'(it.c.ctrl));
            chk("iss_grant", 64'(grant), (it.m == 1) ? 64'd2 : 64'd1);
            chk("iss_busy", 64'(busy), 64'd1);
        end
        if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) rs = rsp_q.pop_front();
        d0 = rsp_q.size() > 0 && rsp_q[0].cyc == cyc && rsp_q[0].m == 0;
        d1 = rsp_q.size() > 0 && rsp_q[0].cyc == cyc && rsp_q[0].m == 1;
        chk("m0_ready", 64'(m0_ready), 64'(d0));
        chk("m1_ready", 64'(m1_ready), 64'(d1));
        if ((m0_ready || m1_ready) && rsp_q.size() > 0) begin
            rs = rsp_q.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(rs.cyc));
            chk("rsp_grant", 64'(grant), (rs.m == 1) ? 64'd2 : 64'd1);
            chk("m0_rdata", 64'(m0_rdata), 64'(rs.rd0));
            chk("m1_rdata", 64'(m1_rdata), 64'(rs.rd1));
        end
    end

    initial begin
        lsc[0] = LS_B; lsc[1] = LS_H; lsc[2] = LS_W;
        lsc[3] = LS_BU; lsc[4] = LS_HU;
        reset = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        slave_mem[32'h20] = 32'h1234_5678;
        ref_mem[32'h20]   = 32'h1234_5678;
        apply_reset(3);

        // Both masters request continuously straight out of reset.
        script0.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF, LS_W));
        script1.push_back(mk(1'b0, 32'h20, 32'h0, LS_W));
        script0.push_back(mk(1'b0, 32'h3, 32'h0, LS_HU));
        script1.push_back(mk(1'b0, 32'h10, 32'h0, LS_W));
        script0.push_back(mk(1'b1, 32'h3, 32'h0000_A5A5, LS_H));
        script1.push_back(mk(1'b1, 32'h24, 32'hCAFE_F00D, LS_B));
        settle();

        run(400, 1'b1);
        settle();

        // Read aborted by reset while waiting on the slave.
        script0.push_back(mk(1'b0, 32'h30, 32'h0, LS_W));
        run(3, 1'b0);
        apply_reset(2);

        script0.push_back(mk(1'b0, 32'h24, 32'h0, LS_BU));
        script1.push_back(mk(1'b0, 32'h10, 32'h0, LS_W));
        settle();

        run(200, 1'b1);
        settle();
        run(4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
